// File: rtl/crc_engine_pkg.sv
// crc_engine_pkg: shared state enum and CRC helper functions for crc_stream_engine
package crc_engine_pkg;
  typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;
  // one byte of the serial MSB-first LFSR, data bit 7 enters first; width <= 32
  function automatic logic [31:0] crc_byte_next(input logic [31:0] crc, input logic [7:0] data,
                                                input logic [31:0] poly, input int width);
    logic [31:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[5'(width - 1)] ^ data[3'(i)];
      c = (c << 1) ^ (fb ? poly : 32'd0);
    end
    return width == 32 ? c : c & ((32'd1 << width) - 32'd1);
  endfunction
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < width) r[5'(i)] = v[5'(width - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/crc_byte_step.sv
// crc_byte_step: combinational one-byte CRC LFSR update
// Ports: crc_in (current register), data_in (byte), crc_next (register after the byte).
// REFLECT!=0 feeds bit 0 of the byte first; the register itself stays in normal form.
module crc_byte_step import crc_engine_pkg::*; #(
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] POLYNOMIAL = CRC_W'(16'h8005),
  parameter int REFLECT = 0
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data_in,
  output logic [CRC_W-1:0] crc_next
);
  logic [7:0] data_rev, data_ord;
  always_comb begin
    data_rev = {<<{data_in}};
    data_ord = REFLECT != 0 ? data_rev : data_in;
    crc_next = CRC_W'(crc_byte_next(32'(crc_in), data_ord, 32'(POLYNOMIAL), CRC_W));
  end
endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming per-frame CRC generator (append) / checker (flag)
// Ports: clk_in, rst (sync, active high); s_data/s_valid/s_last/s_ready input stream;
// m_data/m_valid/m_last/m_ready output stream; mode_check (0 generate, 1 check);
// crc_out/crc_out_valid/crc_err per-frame result.
// Macro CRC_CHECK_EN builds check mode (delay buffer + comparator); without it the
// engine is generate-only and crc_err stays 0.
module crc_stream_engine import crc_engine_pkg::*; #(
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] POLYNOMIAL = CRC_W'(16'h8005),
  parameter logic [CRC_W-1:0] INIT_VALUE = CRC_W'(16'hFFFF),
  parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(16'hFFFF),
  parameter int REFLECT = 0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             mode_check,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_out_valid,
  output logic             crc_err
);
  localparam int N = CRC_W / 8;
  localparam logic [2:0] NB = 3'(N);
  state_t state;
  logic [CRC_W-1:0] crc_q, crc_cur, crc_step, crc_nx, crc_fin;
  logic [2:0] app_cnt;
  logic [5:0] sh;
  logic [7:0] feed, emit;
  logic acc, chk, feed_en, mism;
  assign s_ready = ~rst & (~m_valid | m_ready) & (state != APPEND);
  assign acc = s_valid & s_ready;
  assign crc_cur = state == IDLE ? INIT_VALUE : crc_q;
`ifdef CRC_CHECK_EN
  logic is_check;
  logic [2:0] cnt, cnt_cur;
  logic [CRC_W-1:0] sbuf, sbuf_nx, fin_swap, exp_buf;
  // the CRC only sees bytes leaving the N-byte delay line, so the trailing
  // received CRC bytes never enter it; at s_last the line holds exactly them
  always_comb begin
    chk = state == IDLE ? mode_check : is_check;
    cnt_cur = state == IDLE ? 3'd0 : cnt;
    feed_en = ~chk | (cnt_cur >= NB);
    feed = chk ? sbuf[CRC_W-1 -: 8] : s_data;
    sbuf_nx = CRC_W'({sbuf, s_data});
  end
  always_comb begin
    fin_swap = {<<8{crc_fin}};
    exp_buf = REFLECT != 0 ? fin_swap : crc_fin;
    mism = (cnt_cur < NB) | (sbuf_nx != exp_buf);
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      is_check <= 1'b0;
      cnt <= 3'd0;
      sbuf <= '0;
    end else if (acc) begin
      is_check <= chk;
      cnt <= cnt_cur >= NB ? NB : cnt_cur + 3'd1;
      sbuf <= sbuf_nx;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode_check;
  assign chk = 1'b0;
  assign feed_en = 1'b1;
  assign feed = s_data;
  assign mism = 1'b0;
`endif
  crc_byte_step #(.CRC_W(CRC_W), .POLYNOMIAL(POLYNOMIAL), .REFLECT(REFLECT)) u_step (
    .crc_in(crc_cur),
    .data_in(feed),
    .crc_next(crc_step)
  );
  always_comb begin
    crc_nx = feed_en ? crc_step : crc_cur;
    crc_fin = (REFLECT != 0 ? CRC_W'(bit_reverse(32'(crc_nx), CRC_W)) : crc_nx) ^ XOR_OUT;
    sh = REFLECT != 0 ? {app_cnt, 3'b0} : 6'(CRC_W - 8) - {app_cnt, 3'b0};
    emit = 8'(crc_out >> sh);
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
      crc_q <= '0;
      app_cnt <= 3'd0;
      m_data <= 8'd0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      crc_out <= '0;
      crc_out_valid <= 1'b0;
      crc_err <= 1'b0;
    end else begin
      crc_out_valid <= 1'b0;
      if (m_valid & m_ready) begin
        m_valid <= 1'b0;
        m_last <= 1'b0;
      end
      if (acc) begin
        m_data <= s_data;
        m_valid <= 1'b1;
        m_last <= s_last & chk;
        crc_q <= crc_nx;
        app_cnt <= 3'd0;
        state <= ~s_last ? DATA : chk ? IDLE : APPEND;
        if (s_last) begin
          crc_out <= crc_fin;
          crc_out_valid <= 1'b1;
          crc_err <= chk & mism;
        end
      end else if (state == APPEND) begin
        if ((~m_valid | m_ready) && app_cnt != NB) begin
          m_data <= emit;
          m_valid <= 1'b1;
          m_last <= app_cnt == NB - 3'd1;
          app_cnt <= app_cnt + 3'd1;
        end
        if (m_valid & m_ready & m_last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: directed and backpressure checks of crc_stream_engine in three configurations
module tb_crc_stream_engine;
  typedef struct {
    int dut;
    bit chk;
    int len;
    logic [7:0] d[12];
    logic [31:0] crc;
    bit ck;
    bit err;
  } vec_t;
  logic clk = 0, rst = 1, mode_check = 0, s_valid = 0, s_last = 0, m_ready = 1;
  logic [7:0] s_data = 0;
  logic sr_v[3], mv_v[3], ml_v[3], cv_v[3], ce_v[3];
  logic [7:0] md_v[3];
  logic [15:0] c0, c2;
  logic [31:0] c1;
  logic sr, mv, ml, cv, ce;
  logic [7:0] md;
  logic [31:0] co;
  int sel = 0, errors = 0, checks = 0;
  bit bp = 0;
  logic [8:0] oq[$];
  logic [32:0] cq[$];
  vec_t vec[7];
  int cw[3] = '{16, 32, 16};
  logic [31:0] cpoly[3] = '{32'h8005, 32'h04C11DB7, 32'h1021};
  logic [31:0] cinit[3] = '{32'h0, 32'hFFFFFFFF, 32'hFFFF};
  logic [31:0] cxor[3] = '{32'h0, 32'hFFFFFFFF, 32'h0};
  bit crf[3] = '{0, 1, 0};

  always #5 clk = ~clk;

  crc_stream_engine #(.CRC_W(16), .POLYNOMIAL(16'h8005), .INIT_VALUE(16'h0000), .XOR_OUT(16'h0000), .REFLECT(0)) u0 (
    .clk_in(clk), .rst(rst), .mode_check(mode_check), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(sr_v[0]), .m_data(md_v[0]), .m_valid(mv_v[0]), .m_last(ml_v[0]), .m_ready(m_ready),
    .crc_out(c0), .crc_out_valid(cv_v[0]), .crc_err(ce_v[0]));
  crc_stream_engine #(.CRC_W(32), .POLYNOMIAL(32'h04C11DB7), .INIT_VALUE(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF), .REFLECT(1)) u1 (
    .clk_in(clk), .rst(rst), .mode_check(mode_check), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(sr_v[1]), .m_data(md_v[1]), .m_valid(mv_v[1]), .m_last(ml_v[1]), .m_ready(m_ready),
    .crc_out(c1), .crc_out_valid(cv_v[1]), .crc_err(ce_v[1]));
  crc_stream_engine #(.CRC_W(16), .POLYNOMIAL(16'h1021), .INIT_VALUE(16'hFFFF), .XOR_OUT(16'h0000), .REFLECT(0)) u2 (
    .clk_in(clk), .rst(rst), .mode_check(mode_check), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(sr_v[2]), .m_data(md_v[2]), .m_valid(mv_v[2]), .m_last(ml_v[2]), .m_ready(m_ready),
    .crc_out(c2), .crc_out_valid(cv_v[2]), .crc_err(ce_v[2]));

  always_comb begin
    sr = sr_v[sel];
    mv = mv_v[sel];
    ml = ml_v[sel];
    cv = cv_v[sel];
    ce = ce_v[sel];
    md = md_v[sel];
    co = sel == 0 ? {16'h0, c0} : sel == 1 ? c1 : {16'h0, c2};
  end

  always @(negedge clk)
    if (!rst) begin
      if (mv && m_ready) oq.push_back({ml, md});
      if (cv) cq.push_back({ce, co});
    end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rev(input logic [31:0] v, input int w);
    logic [31:0] r = 0;
    for (int k = 0; k < w; k++)
      if ((v & (32'd1 << k)) != 0) r |= 32'd1 << (w - 1 - k);
    return r;
  endfunction

  // reference CRC: classic MSB-first shifter, or right-shifting reflected form
  function automatic logic [31:0] model(input int i);
    int u = vec[i].dut;
    int w = cw[u];
    logic [31:0] c, p, m;
    m = w == 32 ? 32'hFFFFFFFF : (32'd1 << w) - 1;
    if (crf[u]) begin
      c = rev(cinit[u], w);
      p = rev(cpoly[u], w);
      for (int j = 0; j < vec[i].len; j++) begin
        c ^= {24'h0, vec[i].d[j]};
        for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ p : c >> 1;
      end
    end else begin
      c = cinit[u];
      for (int j = 0; j < vec[i].len; j++) begin
        c ^= {24'h0, vec[i].d[j]} << (w - 8);
        for (int b = 0; b < 8; b++)
          c = ((c >> (w - 1)) & 32'd1) != 0 ? ((c << 1) ^ cpoly[u]) & m : (c << 1) & m;
      end
    end
    return (c ^ cxor[u]) & m;
  endfunction

  task automatic setv(input int i, input int dut, input bit chk, input string s,
                      input logic [31:0] crc, input bit ck, input bit err);
    vec[i].dut = dut;
    vec[i].chk = chk;
    vec[i].len = s.len();
    vec[i].crc = crc;
    vec[i].ck = ck;
    vec[i].err = err;
    for (int j = 0; j < s.len(); j++) vec[i].d[j] = s[j];
  endtask

  task automatic addb(input int i, input logic [7:0] b);
    vec[i].d[vec[i].len] = b;
    vec[i].len++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    s_valid = 0;
    s_last = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_s_ready", sr, 0);
    @(posedge clk);
    #1;
    rst = 0;
    oq.delete();
    cq.delete();
  endtask

  task automatic wait_acc(output bit ok);
    int t = 0;
    @(negedge clk);
    while (!sr && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = sr;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_ready got 0 for 300 cycles expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i);
    bit ok;
    @(posedge clk);
    #1;
    for (int j = 0; j < vec[i].len; j++) begin
      s_valid = 1;
      s_data = vec[i].d[j];
      s_last = j == vec[i].len - 1;
      mode_check = j == 0 ? vec[i].chk : ~vec[i].chk;
      wait_acc(ok);
      if (!ok) begin
        s_valid = 0;
        s_last = 0;
        return;
      end
    end
    s_valid = 0;
    s_last = 0;
    @(negedge clk);
    check("crc_valid_latency", cv, 1);
    check("data_latency", md, vec[i].d[vec[i].len - 1]);
    if (vec[i].chk) check("b2b_ready", sr, 1);
  endtask

  task automatic run(input int i);
    logic [8:0] exp[$];
    logic [31:0] e, t;
    int w, n;
    if (vec[i].dut != sel) begin
      sel = vec[i].dut;
      do_reset();
    end
    e = vec[i].crc;
    w = cw[sel];
    for (int j = 0; j < vec[i].len; j++) exp.push_back({vec[i].chk && j == vec[i].len - 1, vec[i].d[j]});
    if (!vec[i].chk)
      for (int k = 0; k < w / 8; k++) begin
        t = e >> (crf[sel] ? 8 * k : w - 8 - 8 * k);
        exp.push_back({k == w / 8 - 1, t[7:0]});
      end
    send(i);
    n = 0;
    while ((oq.size() < exp.size() || cq.size() < 1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("out_count", oq.size(), exp.size());
    if (oq.size() == exp.size())
      foreach (exp[k]) check($sformatf("out_byte%0d", k), {23'h0, oq[k]}, {23'h0, exp[k]});
    check("crc_pulses", cq.size(), 1);
    if (cq.size() > 0) begin
      if (vec[i].ck) check("crc_out", cq[0][31:0], e);
      check("crc_err", {31'h0, cq[0][32]}, {31'h0, vec[i].err});
    end
    oq.delete();
    cq.delete();
  endtask

  initial begin
    bit ok;
    int nl;
    setv(0, 0, 0, "123456789", 32'hFEE8, 1, 0);
    setv(1, 1, 0, "123456789", 32'hCBF43926, 1, 0);
    setv(2, 2, 1, "123456789", 32'h29B1, 1, 0);
    addb(2, 8'h29);
    addb(2, 8'hB1);
    setv(3, 2, 1, "123456789", 32'h29B1, 1, 1);
    addb(3, 8'h29);
    addb(3, 8'hB0);
    setv(4, 2, 1, "AB", 32'h0, 0, 1);
    setv(5, 2, 0, "A", 32'hB915, 1, 0);
    @(negedge clk);
    check("reset_s_ready_init", sr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("post_reset_s_ready", sr, 1);
    check("post_reset_m_valid", mv, 0);
    check("post_reset_m_last", ml, 0);
    check("post_reset_m_data", md, 0);
    check("post_reset_crc_out", co, 0);
    check("post_reset_crc_valid", cv, 0);
    check("post_reset_crc_err", ce, 0);
    for (int i = 0; i < 6; i++) begin
`ifdef CRC_CHECK_EN
      run(i);
`else
      if (!vec[i].chk) run(i);
`endif
    end
    bp = 1;
    for (int f = 0; f < 100; f++) begin
      vec[6].dut = 0;
      vec[6].chk = 0;
      vec[6].ck = 1;
      vec[6].err = 0;
      vec[6].len = $urandom_range(1, 12);
      for (int j = 0; j < vec[6].len; j++) vec[6].d[j] = 8'($urandom);
      vec[6].crc = model(6);
      run(6);
    end
    bp = 0;
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      s_valid = 1;
      s_data = vec[0].d[j];
      s_last = 0;
      mode_check = 0;
      wait_acc(ok);
    end
    s_data = vec[0].d[4];
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    s_valid = 0;
    @(negedge clk);
    check("midrst_m_valid", mv, 0);
    check("midrst_m_data", md, 0);
    check("midrst_m_last", ml, 0);
    check("midrst_s_ready", sr, 1);
    repeat (6) @(negedge clk);
    nl = 0;
    foreach (oq[k]) if (oq[k][8]) nl++;
    check("midrst_no_pulse", cq.size(), 0);
    check("midrst_no_last", nl, 0);
    oq.delete();
    cq.delete();
    run(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised streaming CRC engine for the downlink framing path; successor to the fixed byte-wise CRC-16 calculator. It accepts a byte stream with valid/ready/last framing, computes a configurable CRC of 8 to 32 bits per frame and operates in one of two modes. In generate mode it forwards the frame and appends the CRC bytes. In check mode it forwards the frame unchanged and flags a CRC mismatch. It sits between the frame builder and the serialiser (TX) or the deframer and the payload sink (RX).

## Interface
- CRC_W, 16, CRC width in bits: 8, 16, 24 or 32.
- POLYNOMIAL, 16'h8005, generator polynomial, normal (non-reflected) form, CRC_W bits.
- INIT_VALUE, 16'hFFFF, CRC register value at frame start.
- XOR_OUT, 16'hFFFF, value XORed into the final register to form the output CRC.
- REFLECT, 0, 0: bit 7 of each byte enters first, CRC emitted MSB-byte first; 1: bit 0 enters first, final register bit-reversed, CRC emitted LSB-byte first.
- clk_in  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- mode_check  input  1  0 = generate, 1 = check; sampled only in IDLE on the first accepted byte.
- s_data  input  8  input byte.
- s_valid  input  1  input byte valid.
- s_last  input  1  marks the final byte of the frame.
- s_ready  output  1  input byte accepted when s_valid & s_ready.
- m_data  output  8  output byte.
- m_valid  output  1  output byte valid.
- m_last  output  1  final byte of the output frame.
- m_ready  input  1  downstream accept.
- crc_out  output  CRC_W  final CRC, after reflection and XOR_OUT; held until the next pulse.
- crc_out_valid  output  1  one-cycle pulse per completed frame.
- crc_err  output  1  check mode only: mismatch or runt; qualified by crc_out_valid.

## Operation
- States: IDLE, DATA, APPEND.
  - IDLE → DATA on the first accepted byte, or → APPEND/IDLE if that byte carries s_last.
  - DATA → APPEND on the accepted s_last byte in generate mode.
  - DATA → IDLE on the accepted s_last byte in check mode.
  - APPEND → IDLE after the last CRC byte is accepted downstream.
- CRC register loads INIT_VALUE on entry to a frame. Each CRC byte step is the standard serial LFSR update unrolled 8 times.
- Generate mode:
  - Every input byte is forwarded and fed to the CRC.
  - In APPEND, s_ready=0 and N=CRC_W/8 CRC bytes are emitted; m_last is set only on the final one.
- Check mode:
  - Every input byte is forwarded unchanged; m_last follows s_last.
  - An N-byte shift buffer delays the stream. The CRC is fed only with bytes leaving the buffer, so the trailing N bytes (the received CRC) are excluded.
  - At s_last, the buffer contents are compared with the computed CRC in emission order. crc_err=1 on mismatch.
  - Frames of N bytes or fewer are runts: crc_err=1.
- Output register is a single stage: s_ready = (~m_valid | m_ready) and state != APPEND.

## Timing
- Reset values: s_ready 0 during reset then 1; m_valid 0, m_last 0, m_data 0, crc_out 0, crc_out_valid 0, crc_err 0; state IDLE; buffer cleared.
- Latency: input byte to m_data is 1 cycle. crc_out_valid fires 1 cycle after the s_last byte is accepted, in both modes.
- m_data, m_valid and m_last are held stable while m_valid & ~m_ready.
- Back-to-back frames:
  - Check mode: the next frame's first byte may be accepted in the cycle after s_last.
  - Generate mode: the next frame starts the cycle after the final CRC byte is accepted.
- rst mid-frame: the frame is dropped, with no crc_out_valid and no m_last. Outputs return to reset values next cycle.
- mode_check changes mid-frame are ignored.

## Configuration
- CRC_CHECK_EN
  - Defined: check mode, N-byte buffer and comparator are built.
  - Undefined: mode_check is ignored (generate only), crc_err is tied 0, and no buffer is built.

## Structure
- Package crc_engine_pkg holds:
  - the state enum;
  - the functions crc_byte_next(crc, byte, poly, width) and bit_reverse.
- One sub-module, crc_byte_step: combinational one-byte LFSR update, parametrised by CRC_W/POLYNOMIAL/REFLECT. Reusable by wider datapaths.

## Test plan
- Generate, defaults with INIT_VALUE=0, XOR_OUT=0, "123456789" → crc_out=16'hFEE8; bytes FE, E8 appended; m_last on E8.
- Generate, CRC_W=32, POLYNOMIAL=32'h04C11DB7, INIT/XOR=32'hFFFFFFFF, REFLECT=1, "123456789" → crc_out=32'hCBF43926; appended 26, 39, F4, CB.
- Check mode, CRC_W=16, POLYNOMIAL=16'h1021, INIT_VALUE=16'hFFFF, XOR_OUT=0:
  - "123456789",29,B1 → crc_err=0, crc_out=16'h29B1;
  - same frame with one flipped bit → crc_err=1.
- Random m_ready backpressure (50%) over 100 generate frames → output stream equals input plus reference CRC; no byte lost or duplicated.
- Check-mode runt of 2 bytes with CRC_W=16 → crc_out_valid with crc_err=1; a following 1-byte generate frame is processed correctly.
- rst asserted on byte 5 of a 9-byte frame → no crc_out_valid; the next full frame yields the correct CRC.
